// File: rtl/pipe_elastic.sv
// pipe_elastic: a chain of STAGES register slots for a WIDTH-bit payload.
// Each slot has its own valid bit. The chain uses valid/ready handshaking
// with bubble collapse, so an empty slot always takes a payload from the slot
// behind it, even when the output is stalled. It also has a synchronous flush
// and an occupancy counter that tracks the number of valid slots.
module pipe_elastic #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned STAGES = 3,
    localparam int unsigned OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] slotValid;
    logic [WIDTH-1:0]  slotData [STAGES];
    logic [STAGES-1:0] slotRdy;
    logic [OCC_W-1:0]  occReg;
    logic              inXfer;
    logic              outXfer;

    // Ready chain: a slot can load when it is empty or its own content moves on.
    // The chain is walked from the output back to slot 0 through one running
    // term, so that no vector reads back its own bits.
    always_comb begin
        logic r;
        r       = out_ready;
        slotRdy = '0;
        for (int unsigned i = STAGES; i > 0; i--) begin
            r            = ~slotValid[i-1] | r;
            slotRdy[i-1] = r;
        end
    end

    // Handshake outputs. A flush masks both transfers for the cycle it is seen.
    always_comb begin
        in_ready    = slotRdy[0] & ~flush;
        out_valid   = slotValid[STAGES-1] & ~flush;
        out_data    = slotData[STAGES-1];
        stage_valid = slotValid;
        occupancy   = occReg;
        inXfer      = in_valid & in_ready;
        outXfer     = out_valid & out_ready;
    end

    // Slot advance. Reset clears everything. Flush drops only the valid bits.
    // Data registers load only when a valid payload arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slotValid <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                slotData[i] <= '0;
            end
        end else if (flush) begin
            slotValid <= '0;
        end else begin
            if (slotRdy[0]) begin
                slotValid[0] <= in_valid;
                if (in_valid) begin
                    slotData[0] <= in_data;
                end
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (slotRdy[i]) begin
                    slotValid[i] <= slotValid[i-1];
                    if (slotValid[i-1]) begin
                        slotData[i] <= slotData[i-1];
                    end
                end
            end
        end
    end

    // Occupancy counts +1 on an input transfer only and -1 on an output
    // transfer only. It returns to zero on reset or flush.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occReg <= '0;
        end else begin
            case ({inXfer, outXfer})
                2'b10:   occReg <= occReg + OCC_W'(1);
                2'b01:   occReg <= occReg - OCC_W'(1);
                default: occReg <= occReg;
            endcase
        end
    end

    // The counter must always agree with the number of valid slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (occReg == OCC_W'($countones(slotValid)));
        end
    end

endmodule

// File: tb/tb_pipe_elastic.sv
// Self-checking bench for pipe_elastic (STAGES=3, WIDTH=32). A slot-position
// model and an ordered scoreboard predict all outputs every cycle.
module tb_pipe_elastic;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 3;
    localparam int unsigned OW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic [S-1:0]  stage_valid;
    logic [OW-1:0] occupancy;

    int errors = 0;
    int checks = 0;

    // Model: which positions hold an item, what each position's register holds.
    bit           mv [S];
    logic [W-1:0] md [S];
    bit           modelLive = 1'b0;
    logic [W-1:0] sb [$];

    pipe_elastic #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .stage_valid(stage_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, take the edge,
    // then advance the model.
    task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit fl, input bit rs);
        int           cnt;
        bit           anyEmpty;
        bit           expIr;
        bit           expOv;
        logic [S-1:0] sv;
        logic [W-1:0] e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        if (modelLive) begin
            cnt      = 0;
            anyEmpty = 1'b0;
            for (int i = 0; i < S; i++) begin
                sv[i] = mv[i];
                cnt  += int'(mv[i]);
                if (!mv[i]) anyEmpty = 1'b1;
            end
            // Input is possible whenever any position is free or the output drains.
            expIr = (anyEmpty | ordy) & ~fl;
            expOv = mv[S-1] & ~fl;
            checkVal("in_ready", in_ready, expIr);
            checkVal("out_valid", out_valid, expOv);
            checkVal("out_data", out_data, md[S-1]);
            checkVal("stage_valid", stage_valid, sv);
            checkVal("occupancy", occupancy, cnt);
            if (expOv && ordy && rs) begin
                if (sb.size() == 0) begin
                    checkVal("sb_unexpected_out", out_data, 0);
                end else begin
                    e = sb.pop_front();
                    checkVal("order", out_data, e);
                end
            end
            if (iv && expIr && rs) sb.push_back(id);
        end
        @(posedge clk);
        if (!rs) begin
            for (int i = 0; i < S; i++) begin
                mv[i] = 1'b0;
                md[i] = '0;
            end
            sb.delete();
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (fl) begin
                for (int i = 0; i < S; i++) mv[i] = 1'b0;
                sb.delete();
            end else begin
                // Items leave from the front, then each one steps into a free
                // position ahead of it, then a new item enters position 0.
                if (mv[S-1] && ordy) mv[S-1] = 1'b0;
                for (int p = S - 2; p >= 0; p--) begin
                    if (mv[p] && !mv[p+1]) begin
                        mv[p+1] = 1'b1;
                        md[p+1] = md[p];
                        mv[p]   = 1'b0;
                    end
                end
                if (iv && !mv[0]) begin
                    mv[0] = 1'b1;
                    md[0] = id;
                end
            end
        end
        #2;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] vals [4];
        int           guard;
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;

        // Reset
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_data", out_data, 0);
        checkVal("rst_stage_valid", stage_valid, 0);
        checkVal("rst_occupancy", occupancy, 0);
        checkVal("rst_in_ready", in_ready, 1);

        // Latency: the payload is visible only after the third edge
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        checkVal("lat_e0_valid", out_valid, 0);
        idle(1, 1'b1);
        checkVal("lat_e1_valid", out_valid, 0);
        idle(1, 1'b1);
        checkVal("lat_e2_valid", out_valid, 1);
        checkVal("lat_e2_data", out_data, 32'hDEADBEEF);
        idle(1, 1'b1);
        checkVal("lat_e3_valid", out_valid, 0);

        // Streaming 1..10
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, W'(k), 1'b1, 1'b0, 1'b1);
            checkVal("stream_in_ready", in_ready, 1);
            if (k >= 3) checkVal("stream_occ", occupancy, 3);
        end
        idle(4, 1'b1);
        checkVal("stream_sb_empty", sb.size(), 0);

        // Backpressure fill, then drain
        for (int k = 0; k < 4; k++) cycle(1'b1, vals[k], 1'b0, 1'b0, 1'b1);
        checkVal("bp_stage_valid", stage_valid, 3'b111);
        checkVal("bp_occ", occupancy, 3);
        checkVal("bp_in_ready", in_ready, 0);
        cycle(1'b1, vals[3], 1'b1, 1'b0, 1'b1);
        checkVal("bp_full_occ", occupancy, 3);
        guard = 0;
        while (stage_valid != '0 && guard < 10) begin
            idle(1, 1'b1);
            guard++;
        end
        checkVal("bp_drain_timeout", stage_valid, 0);
        checkVal("bp_sb_empty", sb.size(), 0);

        // Bubble collapse under backpressure
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        checkVal("bub_stage_valid", stage_valid, 3'b110);
        checkVal("bub_d2", out_data, 32'h11);
        checkVal("bub_d1", dut.slotData[1], 32'h22);
        idle(4, 1'b1);

        // Flush with a payload presented
        for (int k = 1; k <= 3; k++) cycle(1'b1, W'(k), 1'b0, 1'b0, 1'b1);
        checkVal("fl_pre_occ", occupancy, 3);
        cycle(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
        checkVal("fl_stage_valid", stage_valid, 0);
        checkVal("fl_occ", occupancy, 0);
        checkVal("fl_out_valid", out_valid, 0);
        idle(4, 1'b1);

        // Reset mid-stream with two valid slots
        cycle(1'b1, 32'h71, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h72, 1'b0, 1'b0, 1'b1);
        checkVal("mr_pre_occ", occupancy, 2);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkVal("mr_out_valid", out_valid, 0);
        checkVal("mr_out_data", out_data, 0);
        checkVal("mr_occ", occupancy, 0);
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(32'h80 + k), 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkVal("mr_sb_empty", sb.size(), 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(3, 0) != 0, $urandom, $urandom_range(9, 0) < 6,
                  $urandom_range(39, 0) == 0, $urandom_range(59, 0) != 0);
        end
        idle(6, 1'b1);
        checkVal("rand_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
